// File: rtl/mult_div_unit_pkg.sv
// Op-code constants shared by ALUControl, ALU and the multiply/divide unit,
// plus small decode helpers.
package mult_div_unit_pkg;

  localparam logic [4:0] OPMULT  = 5'h10;
  localparam logic [4:0] OPMULTU = 5'h11;
  localparam logic [4:0] OPDIV   = 5'h12;
  localparam logic [4:0] OPDIVU  = 5'h13;
  localparam logic [4:0] OPMADD  = 5'h14;
  localparam logic [4:0] OPMADDU = 5'h15;
  localparam logic [4:0] OPMSUB  = 5'h16;
  localparam logic [4:0] OPMSUBU = 5'h17;
  localparam logic [4:0] OPMTHI  = 5'h18;
  localparam logic [4:0] OPMTLO  = 5'h19;
  localparam logic [4:0] OPMFHI  = 5'h1A;
  localparam logic [4:0] OPMFLO  = 5'h1B;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == OPMULT) || (op == OPMULTU) || (op == OPMADD) || (op == OPMADDU) ||
           (op == OPMSUB) || (op == OPMSUBU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OPMULT) || (op == OPDIV) || (op == OPMADD) || (op == OPMSUB);
  endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// 32-iteration restoring divider on unsigned magnitudes; one quotient bit per cycle.
module div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        last
);

  logic [31:0] q, r, d;
  logic [4:0]  cnt;
  logic [32:0] r_shift;
  logic [31:0] r_sub;

  // The partial remainder is always below the divisor, so the low 32 bits
  // of the subtraction are exact whenever the trial succeeds.
  assign r_shift = {r, q[31]};
  assign r_sub   = r_shift[31:0] - d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      r    <= '0;
      d    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (r_shift >= {1'b0, d}) begin
        r <= r_sub;
        q <= {q[30:0], 1'b1};
      end else begin
        r <= r_shift[31:0];
        q <= {q[30:0], 1'b0};
      end
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

  assign last      = busy && (cnt == 5'd31);
  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Handshake: an op is taken on a rising edge where iStart=1, oBusy=0 and iAbort=0;
// oDone pulses for one cycle once HI/LO hold the result.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [4:0]  iALUControl,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic        oBusy,
  output logic        oDone,
  output logic        oDivZero,
  output logic [31:0] oHI,
  output logic [31:0] oLO,
  output logic [31:0] oResult,
  output logic [1:0]  oState
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_e;

  state_e      state;
  logic [4:0]  cnt, op;
  logic [31:0] hi, lo, a_raw, mcand;
  logic [63:0] prod;
  logic        res_neg, rem_neg, div_zero, done, dz;

  logic        accept, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, quot, rem, q_fix, r_fix;
  logic [32:0] mul_sum;
  logic [63:0] mul_p, fix_mul;
  logic        div_busy, div_last;

  assign accept = (state == S_IDLE) && iStart && !iAbort;
  assign a_neg  = iA[31] && is_signed_op(iALUControl);
  assign b_neg  = iB[31] && is_signed_op(iALUControl);
  assign a_mag  = a_neg ? -iA : iA;
  assign b_mag  = b_neg ? -iB : iB;

  // Shift-add: the multiplier sits in prod[31:0] and is consumed LSB first.
  assign mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);

  assign mul_p = res_neg ? -prod : prod;
  always_comb begin
    fix_mul = mul_p;
    if (op == OPMADD || op == OPMADDU)      fix_mul = {hi, lo} + mul_p;
    else if (op == OPMSUB || op == OPMSUBU) fix_mul = {hi, lo} - mul_p;
  end
  assign q_fix = res_neg ? -quot : quot;
  assign r_fix = rem_neg ? -rem : rem;

  div_core u_div (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .start     (accept && is_div_op(iALUControl)),
    .abort     (iAbort),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quot),
    .remainder (rem),
    .busy      (div_busy),
    .last      (div_last)
  );

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op       <= '0;
      hi       <= '0;
      lo       <= '0;
      a_raw    <= '0;
      mcand    <= '0;
      prod     <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (is_mul_op(iALUControl) || is_div_op(iALUControl))) begin
            op       <= iALUControl;
            cnt      <= '0;
            a_raw    <= iA;
            mcand    <= a_mag;
            prod     <= {32'd0, b_mag};
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            div_zero <= (iB == 32'd0);
            state    <= is_mul_op(iALUControl) ? S_MUL : S_DIV;
          end else if (accept && iALUControl == OPMTHI) begin
            hi <= iA;
          end else if (accept && iALUControl == OPMTLO) begin
            lo <= iA;
          end
        end
        S_MUL: begin
          if (iAbort) begin
            state <= S_IDLE;
          end else begin
            prod <= {mul_sum, prod[31:1]};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) state <= S_FIX;
          end
        end
        S_DIV: begin
          if (iAbort || !div_busy) state <= S_IDLE;
          else if (div_last)       state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!iAbort) begin
            done <= 1'b1;
            if (!is_div_op(op)) begin
              {hi, lo} <= fix_mul;
            end else if (div_zero) begin
              hi <= a_raw;
              lo <= 32'hFFFF_FFFF;
              dz <= 1'b1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign oBusy    = (state != S_IDLE);
  assign oDone    = done;
  assign oDivZero = dz;
  assign oHI      = hi;
  assign oLO      = lo;
  assign oState   = state;
  assign oResult  = (iALUControl == OPMFHI) ? hi :
                    (iALUControl == OPMFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected {divzero,HI,LO} pushed at accept,
// a negedge monitor pops and compares on every oDone.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic [4:0]  iALUControl = OPMFHI;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        oBusy, oDone, oDivZero;
  logic [31:0] oHI, oLO, oResult;
  logic [1:0]  oState;

  logic [64:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iAbort(iAbort),
    .iALUControl(iALUControl), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oDivZero(oDivZero),
    .oHI(oHI), .oLO(oLO), .oResult(oResult), .oState(oState)
  );

  // clock / watchdog
  always #5 iCLK = ~iCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge iCLK) begin
    logic [64:0] e;
    if (oDone) begin
      done_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=%0h required=none", {oDivZero, oHI, oLO});
      end else begin
        e = exp_q.pop_front();
        if ({oDivZero, oHI, oLO} !== e) begin
          errors++;
          $display("FAIL result actual=%0h required=%0h", {oDivZero, oHI, oLO}, e);
        end
      end
    end else if (oDivZero) begin
      checks++;
      errors++;
      $display("FAIL divzero_without_done actual=1 required=0");
    end
  end

  // driver tasks
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (cyc < 100) begin
      @(negedge iCLK);
      cyc++;
      if (oBusy) busy_n++;
      if (oDone) break;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dz, input logic [31:0] hi,
                        input logic [31:0] lo);
    int cyc, busy_n;
    iALUControl = op; iA = a; iB = b; iStart = 1'b1;
    @(posedge iCLK);
    exp_q.push_back({dz, hi, lo});
    #1 iStart = 1'b0;
    wait_done(cyc, busy_n);
    check({name, "_latency"}, 64'(cyc), 64'd34);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
    model_hi = hi;
    model_lo = lo;
  endtask

  task automatic write_hilo(input string name, input logic [4:0] op, input logic [31:0] a);
    iALUControl = op; iA = a; iStart = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    check({name, "_no_busy"}, 64'(oBusy), 64'd0);
    if (op == OPMTHI) model_hi = a;
    else              model_lo = a;
  endtask

  initial begin
    int cyc, busy_n, d0;

    // reset state
    repeat (3) @(negedge iCLK);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done_dz", 64'({oDone, oDivZero}), 64'd0);
    check("rst_hilo", {oHI, oLO}, 64'd0);
    check("rst_state", 64'(oState), 64'd0);
    check("rst_result", 64'(oResult), 64'd0);
    iRST_n = 1'b1;
    @(negedge iCLK);

    run_op("mult_m3x5", OPMULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    iALUControl = OPMFHI; #1;
    check("mfhi", 64'(oResult), 64'hFFFF_FFFF);
    iALUControl = OPMULT; #1;
    check("result_other_op", 64'(oResult), 64'd0);
    run_op("multu_max", OPMULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_maxpos", OPMULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001);
    run_op("mult_minneg", OPMULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0);
    run_op("div_m7_2", OPDIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", OPDIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_7_0", OPDIVU, 32'd7, 32'd0, 1'b1, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m7_0", OPDIV, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    run_op("divu_max_16", OPDIVU, 32'hFFFF_FFFF, 32'd16, 1'b0, 32'hF, 32'h0FFF_FFFF);

    // accumulate chain
    write_hilo("mthi", OPMTHI, 32'd0);
    write_hilo("mtlo", OPMTLO, 32'd5);
    @(negedge iCLK);
    check("mthi_mtlo_no_done", 64'(oDone), 64'd0);
    check("mthi_mtlo_hilo", {oHI, oLO}, 64'd5);
    iALUControl = OPMFLO; #1;
    check("mflo", 64'(oResult), 64'd5);
    run_op("madd_3x4", OPMADD, 32'd3, 32'd4, 1'b0, 32'd0, 32'd17);
    run_op("msubu_1x18", OPMSUBU, 32'd1, 32'd18, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("maddu_max_2", OPMADDU, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 32'hFFFF_FFFD);
    run_op("msub_m1x1", OPMSUB, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 32'hFFFF_FFFE);

    // abort together with start in idle
    iALUControl = OPMULT; iA = 32'd9; iB = 32'd9; iStart = 1'b1; iAbort = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0; iAbort = 1'b0;
    check("abort_idle_busy", 64'(oBusy), 64'd0);

    // abort mid divide
    iALUControl = OPDIV; iA = 32'd100; iB = 32'd7; iStart = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    repeat (9) @(posedge iCLK);
    #1;
    check("abort_busy_before", 64'(oBusy), 64'd1);
    iAbort = 1'b1;
    @(posedge iCLK);
    #1 iAbort = 1'b0;
    check("abort_busy_after", 64'(oBusy), 64'd0);
    check("abort_hilo", {oHI, oLO}, {model_hi, model_lo});
    d0 = done_count;
    repeat (40) @(negedge iCLK);
    check("abort_no_done", 64'(done_count), 64'(d0));

    // start held high across a whole multiply: second op taken in the done cycle
    iALUControl = OPMULT; iA = 32'd2; iB = 32'd3; iStart = 1'b1;
    @(posedge iCLK);
    exp_q.push_back({1'b0, 32'd0, 32'd6});
    exp_q.push_back({1'b0, 32'd0, 32'd30});
    #1 iA = 32'd5; iB = 32'd6;
    wait_done(cyc, busy_n);
    check("b2b_first_latency", 64'(cyc), 64'd34);
    check("b2b_first_busy", 64'(busy_n), 64'd33);
    @(posedge iCLK);
    #1 iStart = 1'b0;
    wait_done(cyc, busy_n);
    check("b2b_second_latency", 64'(cyc), 64'd34);
    model_hi = 32'd0;
    model_lo = 32'd30;

    // reset mid divide
    iALUControl = OPDIVU; iA = 32'd1000; iB = 32'd3; iStart = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    repeat (9) @(posedge iCLK);
    #1 iRST_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(oBusy), 64'd0);
    check("rst_mid_done_dz", 64'({oDone, oDivZero}), 64'd0);
    check("rst_mid_hilo", {oHI, oLO}, 64'd0);
    iALUControl = OPMFLO; #1;
    check("rst_mid_result", 64'(oResult), 64'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    d0 = done_count;
    repeat (40) @(negedge iCLK);
    check("rst_mid_no_done", 64'(done_count), 64'(d0));
    check("rst_mid_idle", 64'(oBusy), 64'd0);

    repeat (3) @(negedge iCLK);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
